// File: rtl/codec_write_buffer.sv
// Stereo sample FIFO between the FIR output stage and the audio codec write port.
// Tracks fill level, dropped pairs (overflow) and codec starvation (underrun).
`timescale 1ns/1ps

module codec_write_buffer #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_left,
  input  logic [WIDTH-1:0]           in_right,
  output logic                       in_ready,
  input  logic                       write_ready,
  output logic                       write,
  output logic [WIDTH-1:0]           writedata_left,
  output logic [WIDTH-1:0]           writedata_right,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic [CNT_W-1:0]           overflow_count,
  output logic [CNT_W-1:0]           underrun_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [WIDTH-1:0] mem_left  [DEPTH];
  logic [WIDTH-1:0] mem_right [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          primed;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          drop;
  logic          starve;

  assign full  = (count == FULL_LEVEL);
  assign empty = (count == '0);

  // Handshakes are gated by reset_n so they collapse the instant reset is asserted.
  assign in_ready = reset_n && enable && !full;
  assign write    = reset_n && enable && !empty && write_ready;

  assign push   = in_valid && in_ready;
  assign pop    = write;
  assign drop   = enable && in_valid && full;
  assign starve = enable && primed && write_ready && empty;

  assign fill_level      = count;
  assign writedata_left  = empty ? '0 : mem_left[rd_ptr];
  assign writedata_right = empty ? '0 : mem_right[rd_ptr];

  // NOTE: every variable driven in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // NOTE: the sample storage is deliberately left out of reset; emptiness is tracked by the pointers and count, and an unreset RAM maps onto plain memory cells.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_left[wr_ptr]  <= in_left;
      mem_right[wr_ptr] <= in_right;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      primed <= 1'b0;
    end else if (!enable) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      primed <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        primed <= 1'b1;
      end
      count <= count_next;
    end
  end

  // Diagnostic counters survive a flush and saturate rather than wrap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow_count <= '0;
      underrun_count <= '0;
    end else begin
      if (drop && overflow_count != CNT_MAX)
        overflow_count <= overflow_count + 1'b1;
      if (starve && underrun_count != CNT_MAX)
        underrun_count <= underrun_count + 1'b1;
    end
  end

endmodule
